// File: rtl/pkt_wr_ctrl_pkg.sv
// Shared types and default sizing for the packet write controller slice.
// Holds the FSM state encoding and the saturating-increment helper.
package pkt_proc_pkg;

   localparam int unsigned DEF_DATA_WIDTH  = 32;
   localparam int unsigned DEF_PCK_LEN     = 12;
   localparam int unsigned DEF_MAX_PKT_LEN = 1024;
   localparam int unsigned STAT_WIDTH      = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WRITE    = 2'd1,
      ROLLBACK = 2'd2,
      DISCARD  = 2'd3
   } wr_state_e;

   function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] val);
      return (val == {STAT_WIDTH{1'b1}}) ? val : val + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/pkt_wr_ctrl_if.sv
// Ingress beat, buffer write and buffer status bundle of the packet write controller.
// master = controller side, slave = traffic source / buffer side.
interface pkt_wr_ctrl_if
   import pkt_proc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned PCK_LEN    = DEF_PCK_LEN
);
   logic                  in_valid;
   logic                  in_sop;
   logic                  in_eop;
   logic                  in_err;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic                  buf_wr_en;
   logic                  buf_in_eop;
   logic [DATA_WIDTH-1:0] buf_wr_data;
   logic [PCK_LEN-1:0]    buf_count;
   logic                  buf_pck_drop;
   logic [PCK_LEN-1:0]    buf_count_w;
   logic                  buf_empty_de_assert;
   logic                  buffer_full;
   logic                  almost_full;
   logic                  overflow;

   modport master (
      input  in_valid, in_sop, in_eop, in_err, in_data,
      input  buffer_full, almost_full, overflow,
      output in_ready, buf_wr_en, buf_in_eop, buf_wr_data, buf_count,
      output buf_pck_drop, buf_count_w, buf_empty_de_assert
   );

   modport slave (
      output in_valid, in_sop, in_eop, in_err, in_data,
      output buffer_full, almost_full, overflow,
      input  in_ready, buf_wr_en, buf_in_eop, buf_wr_data, buf_count,
      input  buf_pck_drop, buf_count_w, buf_empty_de_assert
   );
endinterface

// File: rtl/pkt_wr_ctrl_sat_cnt.sv
// 16-bit statistics counter that sticks at all-ones and clears on soft reset.
module pkt_sat_cnt
   import pkt_proc_pkg::*;
(
   input  logic                  clk,
   input  logic                  hw_rst,
   input  logic                  sw_rst,
   input  logic                  inc,
   output logic [STAT_WIDTH-1:0] cnt
);
   logic [STAT_WIDTH-1:0] cnt_r;

   // Counter register: soft clear wins over increment
   always_ff @(posedge clk or negedge hw_rst) begin
      if (!hw_rst) begin
         cnt_r <= '0;
      end else if (sw_rst) begin
         cnt_r <= '0;
      end else if (inc) begin
         cnt_r <= sat_inc(cnt_r);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt = cnt_r;
endmodule

// File: rtl/pkt_wr_ctrl.sv
// Packet write controller: writes ingress beats into the packet buffer with zero latency,
// rolls back partially written packets on abort and keeps ok/drop statistics.
module pkt_wr_ctrl
   import pkt_proc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned PCK_LEN     = DEF_PCK_LEN,
   parameter int unsigned MAX_PKT_LEN = DEF_MAX_PKT_LEN
)(
   input  logic                  clk,
   input  logic                  hw_rst,
   input  logic                  sw_rst,
   input  logic                  cfg_store_fwd,
   pkt_wr_ctrl_if.master         bus,
   output logic [STAT_WIDTH-1:0] pkt_cnt_ok,
   output logic [STAT_WIDTH-1:0] pkt_cnt_drop
);
   if (MAX_PKT_LEN > (2**PCK_LEN) - 1) begin : g_len_chk
      $error("MAX_PKT_LEN is not representable in PCK_LEN bits");
   end

   localparam logic [PCK_LEN-1:0] MAX_CNT = MAX_PKT_LEN[PCK_LEN-1:0];
   localparam logic [PCK_LEN-1:0] ONE_CNT = {{(PCK_LEN-1){1'b0}}, 1'b1};

   wr_state_e             state_r, state_nxt_s;
   logic [PCK_LEN-1:0]    cnt_r, cnt_nxt_s, wr_cnt_s;
   logic [PCK_LEN-1:0]    buf_count_r, count_w_r;
   logic                  eop_flag_r, eop_flag_nxt_s;
   logic                  in_ready_r, pck_drop_r, de_assert_r;
   logic                  accept_s, abort_s, wr_en_s, wr_eop_s;
   logic                  ok_inc_s, drop_inc_s, latch_w_s;
   logic [DATA_WIDTH-1:0] wr_data_s;

   // A beat offered during soft reset is never taken into the buffer
   assign accept_s  = bus.in_valid & in_ready_r & ~sw_rst;
   assign abort_s   = bus.buffer_full | bus.in_err | bus.in_sop | bus.overflow | (cnt_r == MAX_CNT);
   assign wr_data_s = bus.in_data;

   // Next-state, write strobes and counter events
   always_comb begin
      state_nxt_s    = state_r;
      cnt_nxt_s      = cnt_r;
      wr_cnt_s       = cnt_r;
      eop_flag_nxt_s = eop_flag_r;
      wr_en_s        = 1'b0;
      wr_eop_s       = 1'b0;
      ok_inc_s       = 1'b0;
      drop_inc_s     = 1'b0;
      latch_w_s      = 1'b0;
      if (sw_rst) begin
         state_nxt_s    = IDLE;
         cnt_nxt_s      = '0;
         eop_flag_nxt_s = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s && bus.in_sop) begin
                  if (bus.almost_full || bus.in_err) begin
                     drop_inc_s  = 1'b1;
                     state_nxt_s = bus.in_eop ? IDLE : DISCARD;
                  end else if (bus.in_eop) begin
                     wr_en_s  = 1'b1;
                     wr_eop_s = 1'b1;
                     ok_inc_s = 1'b1;
                     wr_cnt_s = ONE_CNT;
                  end else begin
                     wr_en_s     = 1'b1;
                     wr_cnt_s    = ONE_CNT;
                     cnt_nxt_s   = ONE_CNT;
                     state_nxt_s = WRITE;
                  end
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            WRITE: begin
               if (accept_s && abort_s) begin
                  latch_w_s      = 1'b1;
                  eop_flag_nxt_s = bus.in_eop;
                  state_nxt_s    = ROLLBACK;
               end else if (accept_s) begin
                  wr_en_s  = 1'b1;
                  wr_cnt_s = cnt_r + ONE_CNT;
                  if (bus.in_eop) begin
                     wr_eop_s    = 1'b1;
                     ok_inc_s    = 1'b1;
                     cnt_nxt_s   = '0;
                     state_nxt_s = IDLE;
                  end else begin
                     cnt_nxt_s = cnt_r + ONE_CNT;
                  end
               end else begin
                  state_nxt_s = WRITE;
               end
            end
            ROLLBACK: begin
               drop_inc_s  = 1'b1;
               cnt_nxt_s   = '0;
               state_nxt_s = eop_flag_r ? IDLE : DISCARD;
            end
            DISCARD: begin
               if (accept_s && bus.in_eop) begin
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s = DISCARD;
               end
            end
            default: begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = '0;
            end
         endcase
      end
   end

   // State, count and registered buffer-side outputs
   always_ff @(posedge clk or negedge hw_rst) begin
      if (!hw_rst) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         buf_count_r <= '0;
         count_w_r   <= '0;
         eop_flag_r  <= 1'b0;
         in_ready_r  <= 1'b0;
         pck_drop_r  <= 1'b0;
         de_assert_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         cnt_r      <= cnt_nxt_s;
         eop_flag_r <= eop_flag_nxt_s;
         in_ready_r <= (state_nxt_s != ROLLBACK);
         pck_drop_r <= (state_nxt_s == ROLLBACK);
         if (sw_rst) begin
            buf_count_r <= '0;
            count_w_r   <= '0;
            de_assert_r <= 1'b0;
         end else begin
            if (wr_en_s) begin
               buf_count_r <= wr_cnt_s;
            end else if (state_r == ROLLBACK) begin
               buf_count_r <= '0;
            end else begin
               buf_count_r <= buf_count_r;
            end
            count_w_r   <= latch_w_s ? cnt_r : count_w_r;
            // Mode only follows the config between packets
            de_assert_r <= (state_r == IDLE) ? cfg_store_fwd : de_assert_r;
         end
      end
   end

   assign bus.in_ready            = in_ready_r;
   assign bus.buf_wr_en           = wr_en_s;
   assign bus.buf_in_eop          = wr_eop_s;
   assign bus.buf_wr_data         = wr_data_s;
   assign bus.buf_count           = buf_count_r;
   assign bus.buf_pck_drop        = pck_drop_r;
   assign bus.buf_count_w         = count_w_r;
   assign bus.buf_empty_de_assert = de_assert_r;

   pkt_sat_cnt u_cnt_ok (
      .clk    (clk),
      .hw_rst (hw_rst),
      .sw_rst (sw_rst),
      .inc    (ok_inc_s),
      .cnt    (pkt_cnt_ok)
   );

   pkt_sat_cnt u_cnt_drop (
      .clk    (clk),
      .hw_rst (hw_rst),
      .sw_rst (sw_rst),
      .inc    (drop_inc_s),
      .cnt    (pkt_cnt_drop)
   );
endmodule

// File: tb/tb_pkt_wr_ctrl.sv
// Directed bench for pkt_wr_ctrl: drives packets on the falling edge and checks buffer
// writes, rollbacks, statistics and resets against hand-computed expectations.
module tb_pkt_wr_ctrl;
   import pkt_proc_pkg::*;

   logic        clk = 1'b0;
   logic        hw_rst = 1'b1;
   logic        sw_rst = 1'b0;
   logic        cfg_store_fwd = 1'b0;
   logic [15:0] pkt_cnt_ok, pkt_cnt_drop;

   pkt_wr_ctrl_if bus_if ();

   pkt_wr_ctrl dut (
      .clk           (clk),
      .hw_rst        (hw_rst),
      .sw_rst        (sw_rst),
      .cfg_store_fwd (cfg_store_fwd),
      .bus           (bus_if),
      .pkt_cnt_ok    (pkt_cnt_ok),
      .pkt_cnt_drop  (pkt_cnt_drop)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int n_wr, n_eop, n_drop, data_err, last_cw, eop_idx;

   task automatic clr_mon();
      n_wr = 0; n_eop = 0; n_drop = 0; data_err = 0; last_cw = -1; eop_idx = 0;
   endtask

   task automatic sample_cycle();
      if (bus_if.buf_wr_en === 1'b1) begin
         n_wr++;
         if (bus_if.buf_wr_data !== bus_if.in_data) data_err++;
         if (bus_if.buf_in_eop === 1'b1) begin
            n_eop++;
            eop_idx = n_wr;
         end
      end
      if (bus_if.buf_pck_drop === 1'b1) begin
         n_drop++;
         last_cw = int'(bus_if.buf_count_w);
      end
   endtask

   task automatic drive_idle();
      bus_if.in_valid = 1'b0; bus_if.in_sop = 1'b0; bus_if.in_eop = 1'b0; bus_if.in_err = 1'b0;
      bus_if.buffer_full = 1'b0; bus_if.almost_full = 1'b0; bus_if.overflow = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         drive_idle();
         #1 sample_cycle();
      end
   endtask

   // Present one beat and hold it until in_ready is seen (bounded)
   task automatic beat(input logic sop, input logic eop, input logic err, input logic full,
                       input logic af, input logic [31:0] data);
      bit done = 1'b0;
      for (int t = 0; t < 4 && !done; t++) begin
         @(negedge clk);
         bus_if.in_valid = 1'b1; bus_if.in_sop = sop; bus_if.in_eop = eop; bus_if.in_err = err;
         bus_if.buffer_full = full; bus_if.almost_full = af; bus_if.in_data = data;
         #1 sample_cycle();
         if (bus_if.in_ready === 1'b1) done = 1'b1;
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL beat_accept: in_ready=%b, required 1 within 4 cycles", bus_if.in_ready);
      end
   endtask

   task automatic send_pkt(input int len, input int full_at, input int err_at,
                           input int sop_at, input bit af_sop);
      for (int i = 1; i <= len; i++) begin
         beat(i == 1 || i == sop_at, i == len, i == err_at, full_at != 0 && i >= full_at,
              af_sop && i == 1, 32'hA500_0000 | 32'(i));
      end
      idle(2);
   endtask

   task automatic test_reset();
      drive_idle();
      bus_if.in_data = 32'h0;
      #3 hw_rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if (bus_if.in_ready !== 1'b0 || bus_if.buf_count !== 12'd0 || bus_if.buf_count_w !== 12'd0 ||
          bus_if.buf_pck_drop !== 1'b0 || bus_if.buf_empty_de_assert !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: rdy=%b cnt=%0d cw=%0d drop=%b de=%b, required all 0",
                  bus_if.in_ready, bus_if.buf_count, bus_if.buf_count_w, bus_if.buf_pck_drop,
                  bus_if.buf_empty_de_assert);
      end
      total++;
      if (pkt_cnt_ok !== 16'd0 || pkt_cnt_drop !== 16'd0) begin
         bad++;
         $display("FAIL reset_stats: ok=%0d drop=%0d, required 0 0", pkt_cnt_ok, pkt_cnt_drop);
      end
      @(negedge clk) hw_rst = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if (bus_if.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: in_ready=%b, required 1", bus_if.in_ready);
      end
   endtask

   task automatic test_good_pkt();
      clr_mon();
      send_pkt(4, 0, 0, 0, 1'b0);
      total++;
      if (n_wr != 4 || n_eop != 1 || eop_idx != 4 || data_err != 0 || n_drop != 0) begin
         bad++;
         $display("FAIL good_writes: wr=%0d eop=%0d eop_at=%0d derr=%0d drop=%0d, required 4 1 4 0 0",
                  n_wr, n_eop, eop_idx, data_err, n_drop);
      end
      total++;
      if (bus_if.buf_count !== 12'd4 || pkt_cnt_ok !== 16'd1) begin
         bad++;
         $display("FAIL good_count: buf_count=%0d ok=%0d, required 4 1", bus_if.buf_count, pkt_cnt_ok);
      end
   endtask

   task automatic test_full_abort();
      clr_mon();
      send_pkt(6, 3, 0, 0, 1'b0);
      total++;
      if (n_wr != 2 || n_drop != 1 || last_cw != 2 || n_eop != 0 || pkt_cnt_drop !== 16'd1) begin
         bad++;
         $display("FAIL full_rollback: wr=%0d drops=%0d cw=%0d eop=%0d cnt_drop=%0d, required 2 1 2 0 1",
                  n_wr, n_drop, last_cw, n_eop, pkt_cnt_drop);
      end
      clr_mon();
      send_pkt(3, 0, 0, 0, 1'b0);
      total++;
      if (n_wr != 3 || pkt_cnt_ok !== 16'd2 || bus_if.buf_count !== 12'd3) begin
         bad++;
         $display("FAIL full_next_pkt: wr=%0d ok=%0d buf_count=%0d, required 3 2 3",
                  n_wr, pkt_cnt_ok, bus_if.buf_count);
      end
   endtask

   task automatic test_err_on_eop();
      clr_mon();
      send_pkt(4, 0, 4, 0, 1'b0);
      total++;
      if (n_wr != 3 || n_drop != 1 || last_cw != 3 || pkt_cnt_drop !== 16'd2) begin
         bad++;
         $display("FAIL err_eop_rollback: wr=%0d drops=%0d cw=%0d cnt_drop=%0d, required 3 1 3 2",
                  n_wr, n_drop, last_cw, pkt_cnt_drop);
      end
      clr_mon();
      send_pkt(1, 0, 0, 0, 1'b0);
      total++;
      if (n_wr != 1 || n_eop != 1 || pkt_cnt_ok !== 16'd3 || bus_if.buf_count !== 12'd1) begin
         bad++;
         $display("FAIL err_eop_then_idle: wr=%0d eop=%0d ok=%0d buf_count=%0d, required 1 1 3 1",
                  n_wr, n_eop, pkt_cnt_ok, bus_if.buf_count);
      end
   endtask

   task automatic test_idle_drops();
      clr_mon();
      send_pkt(3, 0, 0, 0, 1'b1);
      total++;
      if (n_wr != 0 || n_drop != 0 || pkt_cnt_drop !== 16'd3) begin
         bad++;
         $display("FAIL almost_full_sop: wr=%0d drops=%0d cnt_drop=%0d, required 0 0 3",
                  n_wr, n_drop, pkt_cnt_drop);
      end
      clr_mon();
      beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1111);
      beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h2222);
      idle(1);
      send_pkt(2, 0, 0, 0, 1'b0);
      total++;
      if (n_wr != 2 || n_drop != 0 || pkt_cnt_drop !== 16'd4 || pkt_cnt_ok !== 16'd4) begin
         bad++;
         $display("FAIL ignore_and_err: wr=%0d drops=%0d cnt_drop=%0d ok=%0d, required 2 0 4 4",
                  n_wr, n_drop, pkt_cnt_drop, pkt_cnt_ok);
      end
   endtask

   task automatic test_sop_dup();
      clr_mon();
      send_pkt(5, 0, 0, 3, 1'b0);
      total++;
      if (n_wr != 2 || n_drop != 1 || last_cw != 2 || pkt_cnt_drop !== 16'd5) begin
         bad++;
         $display("FAIL sop_dup: wr=%0d drops=%0d cw=%0d cnt_drop=%0d, required 2 1 2 5",
                  n_wr, n_drop, last_cw, pkt_cnt_drop);
      end
   endtask

   task automatic test_max_len();
      clr_mon();
      send_pkt(1025, 0, 0, 0, 1'b0);
      total++;
      if (n_wr != 1024 || n_drop != 1 || last_cw != 1024 || n_eop != 0 || data_err != 0) begin
         bad++;
         $display("FAIL max_len: wr=%0d drops=%0d cw=%0d eop=%0d derr=%0d, required 1024 1 1024 0 0",
                  n_wr, n_drop, last_cw, n_eop, data_err);
      end
      total++;
      if (pkt_cnt_drop !== 16'd6 || pkt_cnt_ok !== 16'd4) begin
         bad++;
         $display("FAIL max_len_stats: drop=%0d ok=%0d, required 6 4", pkt_cnt_drop, pkt_cnt_ok);
      end
   endtask

   task automatic test_de_assert();
      @(negedge clk) cfg_store_fwd = 1'b1;
      idle(1);
      clr_mon();
      beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h31);
      beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h32);
      cfg_store_fwd = 1'b0;
      beat(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h33);
      total++;
      if (bus_if.buf_empty_de_assert !== 1'b1) begin
         bad++;
         $display("FAIL de_assert_hold: value=%b, required 1", bus_if.buf_empty_de_assert);
      end
      idle(2);
      total++;
      if (bus_if.buf_empty_de_assert !== 1'b0 || n_wr != 3 || pkt_cnt_ok !== 16'd5) begin
         bad++;
         $display("FAIL de_assert_idle: value=%b wr=%0d ok=%0d, required 0 3 5",
                  bus_if.buf_empty_de_assert, n_wr, pkt_cnt_ok);
      end
   endtask

   task automatic test_sw_rst();
      clr_mon();
      beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h51);
      @(negedge clk);
      bus_if.in_valid = 1'b1; bus_if.in_sop = 1'b0; bus_if.in_data = 32'h52;
      sw_rst = 1'b1;
      #1;
      total++;
      if (bus_if.buf_wr_en !== 1'b0) begin
         bad++;
         $display("FAIL sw_rst_write: buf_wr_en=%b, required 0", bus_if.buf_wr_en);
      end
      @(negedge clk);
      sw_rst = 1'b0;
      drive_idle();
      #1;
      total++;
      if (bus_if.buf_count !== 12'd0 || pkt_cnt_ok !== 16'd0 || pkt_cnt_drop !== 16'd0 ||
          bus_if.buf_count_w !== 12'd0) begin
         bad++;
         $display("FAIL sw_rst_clear: buf_count=%0d ok=%0d drop=%0d cw=%0d, required 0 0 0 0",
                  bus_if.buf_count, pkt_cnt_ok, pkt_cnt_drop, bus_if.buf_count_w);
      end
      clr_mon();
      idle(3);
      send_pkt(2, 0, 0, 0, 1'b0);
      total++;
      if (n_drop != 0 || n_wr != 2 || pkt_cnt_ok !== 16'd1 || bus_if.buf_count !== 12'd2) begin
         bad++;
         $display("FAIL sw_rst_after: drops=%0d wr=%0d ok=%0d buf_count=%0d, required 0 2 1 2",
                  n_drop, n_wr, pkt_cnt_ok, bus_if.buf_count);
      end
   endtask

   task automatic test_saturate();
      @(negedge clk);
      force dut.u_cnt_ok.cnt_r = 16'hFFFF;
      @(negedge clk);
      release dut.u_cnt_ok.cnt_r;
      clr_mon();
      send_pkt(2, 0, 0, 0, 1'b0);
      total++;
      if (pkt_cnt_ok !== 16'hFFFF || n_wr != 2) begin
         bad++;
         $display("FAIL ok_saturate: ok=%h wr=%0d, required ffff 2", pkt_cnt_ok, n_wr);
      end
   endtask

   initial begin
      test_reset();
      test_good_pkt();
      test_full_abort();
      test_err_on_eop();
      test_idle_drops();
      test_sop_dup();
      test_max_len();
      test_de_assert();
      test_sw_rst();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
